// File: rtl/key_cmd_pkg.sv
// Shared constants for the keyboard command generator: scan codes and command indices.
package key_cmd_pkg;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned N_CMD = 5;

  typedef logic [CMD_W-1:0] cmd_t;

  // Scan codes as {E0 flag, 8-bit code}
  localparam logic [8:0] KEY_W     = 9'h01D;
  localparam logic [8:0] KEY_S     = 9'h01B;
  localparam logic [8:0] KEY_A     = 9'h01C;
  localparam logic [8:0] KEY_D     = 9'h023;
  localparam logic [8:0] KEY_ENTER = 9'h05A;

  localparam cmd_t CMD_UP = 3'd0;
  localparam cmd_t CMD_DW = 3'd1;
  localparam cmd_t CMD_LT = 3'd2;
  localparam cmd_t CMD_RT = 3'd3;
  localparam cmd_t CMD_CT = 3'd4;

  // One-hot pulse vector for a command index
  function automatic logic [N_CMD-1:0] cmd_onehot(input cmd_t c);
    return N_CMD'(1) << c;
  endfunction

endpackage

// File: rtl/key_code_map.sv
// Combinational scan-code decoder: 9-bit code -> {hit, command index}.
module key_code_map
  import key_cmd_pkg::*;
(
  input  logic [8:0] i_code,
  output logic       o_hit,
  output cmd_t       o_cmd
);

  // Decode mapped keys; every other code is a miss
  always_comb begin
    o_hit = 1'b1;
    o_cmd = CMD_UP;
    case (i_code)
      KEY_W:     o_cmd = CMD_UP;
      KEY_S:     o_cmd = CMD_DW;
      KEY_A:     o_cmd = CMD_LT;
      KEY_D:     o_cmd = CMD_RT;
      KEY_ENTER: o_cmd = CMD_CT;
      default:   o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_cmd_gen.sv
// Turns PS/2 make/break events into single-cycle, rate-limited command pulses.
// Held keys are tracked so auto-repeat yields one press; one pending slot absorbs
// presses that arrive during the lockout window.
module key_cmd_gen
  import key_cmd_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_key_valid,
  input  logic [8:0] i_last_change,
  input  logic       i_key_make,
  output logic       o_up_pulse,
  output logic       o_dw_pulse,
  output logic       o_lt_pulse,
  output logic       o_rt_pulse,
  output logic       o_ct_pulse,
  output logic       o_cmd_busy,
  output logic       o_drop_flag
);

  localparam logic [CNT_W-1:0] LOCKOUT_VAL = CNT_W'(LOCKOUT_CYCLES);

  logic             w_hit;
  cmd_t             w_cmd;
  logic [N_CMD-1:0] r_held, w_held_d;
  logic             w_press;
  logic             w_ready;
  logic             w_emit;
  cmd_t             w_emit_cmd;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_pend_v, w_pend_v_d;
  cmd_t             r_pend_cmd, w_pend_cmd_d;
  logic             r_drop, w_drop_d;
  logic [N_CMD-1:0] r_pulse, w_pulse_d;

  key_code_map u_map (
    .i_code (i_last_change),
    .o_hit  (w_hit),
    .o_cmd  (w_cmd)
  );

  // Held-key tracking; a press is a make on a key not already held, gated by enable
  always_comb begin
    w_held_d = r_held;
    w_press  = 1'b0;
    if (i_key_valid && w_hit) begin
      if (i_key_make) begin
        if (!r_held[w_cmd]) begin
          w_press = i_en;
        end
        w_held_d[w_cmd] = 1'b1;
      end else begin
        w_held_d[w_cmd] = 1'b0;
      end
    end
  end

  // Arbitration between the pending slot and a new press, plus lockout counter
  always_comb begin
    // counter==1 reaches zero this cycle, so it is already safe to emit
    w_ready      = (r_cnt <= CNT_W'(1));
    w_emit       = 1'b0;
    w_emit_cmd   = r_pend_cmd;
    w_pend_v_d   = r_pend_v;
    w_pend_cmd_d = r_pend_cmd;
    w_drop_d     = r_drop;
    if (w_ready) begin
      if (r_pend_v) begin
        w_emit     = 1'b1;
        w_emit_cmd = r_pend_cmd;
        w_pend_v_d = w_press;
        if (w_press) begin
          w_pend_cmd_d = w_cmd;
        end
      end else if (w_press) begin
        w_emit     = 1'b1;
        w_emit_cmd = w_cmd;
      end
    end else if (w_press) begin
      w_pend_v_d   = 1'b1;
      w_pend_cmd_d = w_cmd;
      if (r_pend_v) begin
        w_drop_d = 1'b1;
      end
    end

    if (w_emit) begin
      w_cnt_d = LOCKOUT_VAL;
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end else begin
      w_cnt_d = r_cnt;
    end

    w_pulse_d = w_emit ? cmd_onehot(w_emit_cmd) : '0;
  end

  // State and registered pulse outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held     <= '0;
      r_cnt      <= '0;
      r_pend_v   <= 1'b0;
      r_pend_cmd <= '0;
      r_drop     <= 1'b0;
      r_pulse    <= '0;
    end else begin
      r_held     <= w_held_d;
      r_cnt      <= w_cnt_d;
      r_pend_v   <= w_pend_v_d;
      r_pend_cmd <= w_pend_cmd_d;
      r_drop     <= w_drop_d;
      r_pulse    <= w_pulse_d;
    end
  end

  assign o_up_pulse  = r_pulse[CMD_UP];
  assign o_dw_pulse  = r_pulse[CMD_DW];
  assign o_lt_pulse  = r_pulse[CMD_LT];
  assign o_rt_pulse  = r_pulse[CMD_RT];
  assign o_ct_pulse  = r_pulse[CMD_CT];
  assign o_cmd_busy  = (r_cnt != '0) | r_pend_v;
  assign o_drop_flag = r_drop;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Bench for key_cmd_gen: directed table, reset corner case, randomized run vs. model.
module tb_key_cmd_gen;

  localparam int L_A = 4;
  localparam int L_B = 0;

  logic       clk, rst_n, en, kv, mk;
  logic [8:0] code;
  logic       a_up, a_dw, a_lt, a_rt, a_ct, a_busy, a_drop;
  logic       b_up, b_dw, b_lt, b_rt, b_ct, b_busy, b_drop;
  logic [4:0] a_pulse, b_pulse;

  assign a_pulse = {a_ct, a_rt, a_lt, a_dw, a_up};
  assign b_pulse = {b_ct, b_rt, b_lt, b_dw, b_up};

  key_cmd_gen #(.LOCKOUT_CYCLES(L_A), .CNT_W(8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_key_valid(kv), .i_last_change(code),
    .i_key_make(mk), .o_up_pulse(a_up), .o_dw_pulse(a_dw), .o_lt_pulse(a_lt),
    .o_rt_pulse(a_rt), .o_ct_pulse(a_ct), .o_cmd_busy(a_busy), .o_drop_flag(a_drop)
  );

  key_cmd_gen #(.LOCKOUT_CYCLES(L_B), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_key_valid(kv), .i_last_change(code),
    .i_key_make(mk), .o_up_pulse(b_up), .o_dw_pulse(b_dw), .o_lt_pulse(b_lt),
    .o_rt_pulse(b_rt), .o_ct_pulse(b_ct), .o_cmd_busy(b_busy), .o_drop_flag(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [8:0] code;
    logic       mk;
    logic       en;
    logic [4:0] pulse;   // {ct, rt, lt, dw, up}
    logic       busy;
    logic       drop;
  } vec_t;

  localparam logic [8:0] C_W = 9'h01D, C_S = 9'h01B, C_A = 9'h01C, C_D = 9'h023;
  localparam logic [8:0] C_EN = 9'h05A;

  function automatic vec_t mv(input logic v, input logic [8:0] c, input logic m, input logic e,
                              input logic [4:0] p, input logic b, input logic d);
    vec_t r;
    r.v = v; r.code = c; r.mk = m; r.en = e; r.pulse = p; r.busy = b; r.drop = d;
    return r;
  endfunction

  // Apply one cycle of inputs and land 1 time unit after the sampling edge
  task automatic drive_step(input logic v, input logic [8:0] c, input logic m, input logic e);
    kv = v; code = c; mk = m; en = e;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: lockout expressed as "cycles since last emission decision"
  int  cyc;
  bit  m_held [2][5];
  int  m_last [2];
  bit  m_pv   [2];
  int  m_pc   [2];
  bit  m_drop [2];
  logic [4:0] e_pulse [2];
  logic       e_busy  [2];

  function automatic int key_idx(input logic [8:0] c);
    case (c)
      9'h01D: return 0;
      9'h01B: return 1;
      9'h01C: return 2;
      9'h023: return 3;
      9'h05A: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 5; k++) m_held[j][k] = 1'b0;
      m_last[j] = -1000; m_pv[j] = 1'b0; m_pc[j] = 0; m_drop[j] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic model_step(input int j, input int lk, input logic v, input logic [8:0] c,
                            input logic m, input logic e);
    int  k;
    bit  press, ready;
    k = key_idx(c);
    press = 1'b0;
    ready = (cyc - m_last[j]) >= lk;
    if (v && k >= 0) begin
      if (m) begin
        if (!m_held[j][k]) press = e;
        m_held[j][k] = 1'b1;
      end else begin
        m_held[j][k] = 1'b0;
      end
    end
    e_pulse[j] = 5'd0;
    if (ready && m_pv[j]) begin
      e_pulse[j][m_pc[j]] = 1'b1;
      m_last[j] = cyc;
      m_pv[j] = press;
      m_pc[j] = k;
    end else if (ready && press) begin
      e_pulse[j][k] = 1'b1;
      m_last[j] = cyc;
    end else if (!ready && press) begin
      if (m_pv[j]) m_drop[j] = 1'b1;
      m_pv[j] = 1'b1;
      m_pc[j] = k;
    end
    e_busy[j] = ((cyc + 1 - m_last[j]) <= lk) || m_pv[j];
  endtask

  task automatic do_reset();
    kv = 1'b0; mk = 1'b0; en = 1'b1; code = 9'h0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[26];

  initial begin
    rst_n = 1'b1; kv = 1'b0; mk = 1'b0; en = 1'b1; code = 9'h0;

    //            v  code  mk en  pulse     busy drop
    tbl[0]  = mv(1, C_A,  1, 1, 5'b00100, 1, 0);
    tbl[1]  = mv(0, 9'h0, 0, 1, 5'b00000, 1, 0);
    tbl[2]  = mv(1, C_D,  1, 1, 5'b00000, 1, 0);  // lands in pending
    tbl[3]  = mv(1, C_EN, 1, 1, 5'b00000, 1, 1);  // overwrites pending D
    tbl[4]  = mv(0, 9'h0, 0, 1, 5'b10000, 1, 1);
    tbl[5]  = mv(0, 9'h0, 0, 1, 5'b00000, 1, 1);
    tbl[6]  = mv(0, 9'h0, 0, 1, 5'b00000, 1, 1);
    tbl[7]  = mv(0, 9'h0, 0, 1, 5'b00000, 1, 1);
    tbl[8]  = mv(0, 9'h0, 0, 1, 5'b00000, 0, 1);
    tbl[9]  = mv(1, C_A,  0, 1, 5'b00000, 0, 1);
    tbl[10] = mv(1, C_D,  0, 1, 5'b00000, 0, 1);
    tbl[11] = mv(1, C_EN, 0, 1, 5'b00000, 0, 1);
    tbl[12] = mv(1, C_W,  1, 1, 5'b00001, 1, 1);
    tbl[13] = mv(1, C_W,  1, 1, 5'b00000, 1, 1);  // auto-repeat
    tbl[14] = mv(0, 9'h0, 0, 1, 5'b00000, 1, 1);
    tbl[15] = mv(1, C_W,  1, 1, 5'b00000, 1, 1);
    tbl[16] = mv(1, C_W,  0, 1, 5'b00000, 0, 1);
    tbl[17] = mv(1, C_S,  1, 0, 5'b00000, 0, 1);  // disabled press still sets held
    tbl[18] = mv(1, C_S,  1, 1, 5'b00000, 0, 1);
    tbl[19] = mv(1, C_S,  0, 1, 5'b00000, 0, 1);
    tbl[20] = mv(1, C_S,  1, 1, 5'b00010, 1, 1);
    tbl[21] = mv(1, 9'h11D, 1, 1, 5'b00000, 1, 1); // E0-prefixed W is unmapped
    tbl[22] = mv(1, 9'h029, 1, 1, 5'b00000, 1, 1);
    tbl[23] = mv(0, 9'h0, 0, 1, 5'b00000, 1, 1);
    tbl[24] = mv(0, 9'h0, 0, 1, 5'b00000, 0, 1);
    tbl[25] = mv(0, C_W,  1, 1, 5'b00000, 0, 1);  // no strobe, no event

    do_reset();
    chk("reset_pulse", 32'(a_pulse), 32'd0);
    chk("reset_busy",  32'(a_busy),  32'd0);
    chk("reset_drop",  32'(a_drop),  32'd0);
    repeat (3) drive_step(1'b0, 9'h0, 1'b0, 1'b1);

    for (int i = 0; i < 26; i++) begin
      drive_step(tbl[i].v, tbl[i].code, tbl[i].mk, tbl[i].en);
      chk($sformatf("tbl%0d_pulse", i), 32'(a_pulse), 32'(tbl[i].pulse));
      chk($sformatf("tbl%0d_busy", i),  32'(a_busy),  32'(tbl[i].busy));
      chk($sformatf("tbl%0d_drop", i),  32'(a_drop),  32'(tbl[i].drop));
    end

    // Reset while a lockout and a pending command are live
    repeat (6) drive_step(1'b0, 9'h0, 1'b0, 1'b1);
    drive_step(1'b1, C_W, 1'b1, 1'b1);
    chk("rst_seq_up", 32'(a_pulse), 32'b00001);
    drive_step(1'b1, C_A, 1'b1, 1'b1);
    chk("rst_seq_pend_busy", 32'(a_busy), 32'd1);
    kv = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(a_busy), 32'd0);
    chk("rst_async_drop", 32'(a_drop), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_step(1'b0, 9'h0, 1'b0, 1'b1);
      chk($sformatf("post_rst%0d_pulse", i), 32'(a_pulse), 32'd0);
      chk($sformatf("post_rst%0d_busy", i),  32'(a_busy),  32'd0);
    end

    // Randomized run of both lockout settings against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic       v, m, e;
      logic [8:0] c;
      int         sel;
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: c = C_W;
        1: c = C_S;
        2: c = C_A;
        3: c = C_D;
        4: c = C_EN;
        5: c = 9'h11D;
        default: c = 9'(($urandom_range(0, 511)));
      endcase
      v = ($urandom_range(0, 99) < 45);
      m = ($urandom_range(0, 99) < 65);
      e = ($urandom_range(0, 99) < 85);
      model_step(0, L_A, v, c, m, e);
      model_step(1, L_B, v, c, m, e);
      cyc++;
      drive_step(v, c, m, e);
      chk($sformatf("rndA%0d_pulse", i), 32'(a_pulse), 32'(e_pulse[0]));
      chk($sformatf("rndA%0d_busy", i),  32'(a_busy),  32'(e_busy[0]));
      chk($sformatf("rndA%0d_drop", i),  32'(a_drop),  32'(m_drop[0]));
      chk($sformatf("rndB%0d_pulse", i), 32'(b_pulse), 32'(e_pulse[1]));
      chk($sformatf("rndB%0d_busy", i),  32'(b_busy),  32'(e_busy[1]));
      chk($sformatf("rndB%0d_drop", i),  32'(b_drop),  32'(m_drop[1]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_cmd_gen.md
Name: key_cmd_gen

Overview:
- Sits between Keyboard_Decoder and the game logic (state_control, choose_data_control, fight_data_control).
- Converts raw PS/2 make/break events into clean single-cycle command pulses: up, down, left, right and center.
- Suppresses typematic auto-repeat, so a held key gives exactly one pulse.
- Enforces a minimum spacing between pulses and holds one pending command so fast presses are not lost.

Parameters:
- LOCKOUT_CYCLES, 1_000_000, minimum clk cycles between two emitted pulses; 0 = no spacing.
- CNT_W, 20, lockout counter width; must satisfy 2^CNT_W > LOCKOUT_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz domain of Keyboard_Decoder
- rst  input  1  asynchronous, active-low reset
- en  input  1  1 = accept new press events; 0 = discard them (held tracking continues)
- key_valid  input  1  one-cycle strobe from decoder; a make/break event is present
- last_change  input  9  scan code of the event ({E0 flag, 8-bit code})
- key_make  input  1  qualified by key_valid; 1 = make (key_down[last_change]), 0 = break
- up_pulse  output  1  one-cycle command pulse
- dw_pulse  output  1  one-cycle command pulse
- lt_pulse  output  1  one-cycle command pulse
- rt_pulse  output  1  one-cycle command pulse
- ct_pulse  output  1  one-cycle command pulse
- cmd_busy  output  1  lockout counter non-zero or pending valid
- drop_flag  output  1  sticky; set when a pending command is overwritten

Behaviour:
- Key map, in the shared package:
  - W 9'h01D → up
  - S 9'h01B → dw
  - A 9'h01C → lt
  - D 9'h023 → rt
  - Enter 9'h05A → ct
  - Any other code is ignored entirely.
- Reset (rst=0, asynchronous): all pulses 0, held[4:0]=0, counter=0, pending_valid=0, pending_cmd=0, drop_flag=0, cmd_busy=0.
- held tracking, on key_valid with a mapped code:
  - make with held[k]=0 → press event k; held[k]←1.
  - make with held[k]=1 → auto-repeat; no event.
  - break → held[k]←0; no event.
  - Held tracking is independent of en.
- A press event with en=0 is discarded and leaves drop_flag unchanged.
- Emission: outputs are registered, so latency from the key_valid cycle to the pulse is 1 clk.
  - At most one pulse output is high in any cycle (one-hot or zero).
  - Each pulse is exactly 1 cycle wide.
- Lockout counter:
  - Loaded with LOCKOUT_CYCLES on every emission.
  - Decrements by 1 per cycle while non-zero.
  - Saturates at 0.
- Event arbitration each cycle. "Ready" means counter==0, or counter==1 (i.e. it reaches 0 this cycle).
  - Ready, no pending, new event → emit new event.
  - Ready, pending valid → emit pending and clear it; a same-cycle new event becomes the pending command.
  - Not ready, new event, no pending → store it as pending.
  - Not ready, new event, pending valid → newest overwrites pending; drop_flag←1.
- LOCKOUT_CYCLES=0: counter stays 0 and every event emits 1 cycle later; pending is never used.
- cmd_busy = (counter!=0) | pending_valid, registered-state derived, combinational output.
- drop_flag clears only on reset.
- Reset asserted mid-lockout or with a pending command: both are discarded immediately, and no pulse appears after release.

Decomposition:
- Package key_cmd_pkg holds:
  - scan-code constants KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER;
  - command index encoding CMD_UP=0, CMD_DW=1, CMD_LT=2, CMD_RT=3, CMD_CT=4;
  - command width CMD_W=3.
- One sub-module, key_code_map: combinational 9-bit code → {hit, cmd index}.
- The remaining logic (held register, lockout counter, pending slot, output register) stays in key_cmd_gen.

Test Plan (LOCKOUT_CYCLES=4 unless noted):
- Reset then make W (9'h01D) at cycle 10 → up_pulse=1 at cycle 11 only; cmd_busy=1 for cycles 11-14.
- Make W, then make W repeated every 3 cycles for 30 cycles, then break W → exactly one up_pulse.
- Make A at cycle 10, make D at cycle 12 → lt_pulse at 11, rt_pulse at 15; drop_flag=0.
- Make A at 10, make D at 12, make Enter at 13 → lt_pulse at 11, ct_pulse at 15, no rt_pulse; drop_flag=1.
- en=0, make S → no pulse; then en=1, make S without a break → no pulse (held); break + make S → dw_pulse.
- Make W at 10, reset pulse at 12, make A pending beforehand at 11 → no pulse after reset release; counter=0; drop_flag=0.
